sha256_msg_schedule: RTL and testbench
======================================

// Module: sha256_msg_schedule
// PURPOSE
//  SHA-256 message-schedule expander: the consumer of the sigma1 stage.
//  Accepts one 512-bit block as 16 x 32-bit words (M0 first) and streams W[0..ROUNDS-1] to the compression round.
//  Recurrence: W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] (mod 2^32).
//  Instantiates the existing sigma1 block.
//  sigma0 is built locally: RotireDr(x,7) ^ RotireDr(x,18) ^ DeplasareDr(x,3).
// PARAMETERS
//  ROUNDS  64  number of schedule words emitted per block; legal range 16..64
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   in_word is valid
//  in_ready   out  1   block accepts a message word
//  in_word    in   32  message word, big-endian order M0..M15
//  out_valid  out  1   out_word holds W[out_idx]
//  out_ready  in   1   downstream takes out_word
//  out_word   out  32  schedule word W[t]
//  out_idx    out  6   t of the word presented (0..ROUNDS-1)
//  done       out  1   1-cycle pulse after the last word handshake
// BEHAVIOUR
//  Storage:
//  - Window win[0..15] of 32-bit regs; win[0] = oldest.
//  - cnt: 6-bit counter.
//  - State: LOAD / GEN.
//  Reset (rst=1, async):
//  - state=LOAD, cnt=0, win=0.
//  - in_ready=1, out_valid=0, out_word=0, out_idx=0, done=0.
//  LOAD:
//  - in_ready=1, out_valid=0.
//  - Accept on in_valid&in_ready: win shifts left, in_word enters win[15], cnt++.
//  - On the 16th accept (cnt==15): state->GEN, cnt=0, in_ready drops next cycle.
//  GEN:
//  - in_ready=0, out_valid=1.
//  - out_word=win[0] (combinational from the window), out_idx=cnt.
//  - First out_valid occurs 1 cycle after the 16th input accept.
//  - On out_valid&out_ready:
//    - win shifts left.
//    - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0] (32-bit wrap, carries discarded).
//    - cnt++.
//  - Words t<16 are the raw message; words t>=16 are the expansion.
//  - New-word computation continues past t=ROUNDS-17; it is harmless and is not output.
//  - Handshake at cnt==ROUNDS-1:
//    - state->LOAD, cnt=0, done=1 for exactly one cycle.
//    - in_ready=1 in that same cycle.
//  Stalls:
//  - out_ready=0 holds out_word/out_idx stable; the window does not change.
//  - in_valid=0 in LOAD holds state.
//  - in_valid in GEN is ignored (no accept, no side effect).
//  Reset mid-operation: the partial block is discarded; the block returns to the reset state immediately.
// CONFIGURATION
//  SHA_SCHED_ABORT_EN defined:
//  - Adds input port abort (1 bit).
//  - abort=1 at a clock edge, in any state: state=LOAD, cnt=0, out_valid=0 next cycle, done not asserted.
//  - An abort that coincides with an in or out handshake wins; the handshake has no effect.
//  - Window contents become don't-care.
//  SHA_SCHED_ABORT_EN undefined: no abort port; only rst clears a block in progress.
// TESTING
//  1. "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), out_ready=1
//     -> W0=0x61626380, W15=0x18, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; done after W63.
//  2. Same block with out_ready toggling 1/0 each cycle
//     -> identical word sequence, out_word stable while out_ready=0, 64 handshakes total.
//  3. in_valid gaps during LOAD, plus in_valid held 1 during GEN
//     -> exactly 16 words consumed, in_ready=0 throughout GEN, W sequence unchanged.
//  4. Two back-to-back blocks ("abc" then all-zero)
//     -> done pulses once per block; second block emits 64 zeros; in_ready=1 in the cycle of done.
//  5. rst asserted after 7 loaded words and again at out_idx=30
//     -> outputs return to reset values asynchronously; the next full block produces correct W values.
//  6. (SHA_SCHED_ABORT_EN) abort at out_idx=20 with out_ready=1
//     -> no done pulse, in_ready=1 next cycle, the following block is correct.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander.
// Loads one 512-bit block as 16 x 32-bit words (M0 first), then streams
// W[0..ROUNDS-1] to the compression round under a valid/ready handshake.
//   clk, rst (async, active-high)
//   in_valid/in_ready/in_word     : message word input
//   out_valid/out_ready/out_word  : schedule word output, out_idx = t
//   done                          : 1-cycle pulse after the last output handshake
// Optional feature: define SHA_SCHED_ABORT_EN to add an `abort` input that
// discards the block in progress at the next clock edge.

module sha256_sigma1 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  // ROTR17 ^ ROTR19 ^ SHR10
  assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

module sha256_msg_schedule #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_idx,
  output logic        done
`ifdef SHA_SCHED_ABORT_EN
  ,
  input  logic        abort
`endif
);

  typedef enum logic {
    LOAD = 1'b0,
    GEN  = 1'b1
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic        done_q, done_d;

  logic [31:0] s0;
  logic [31:0] s1;
  logic [31:0] new_word;

  // sigma0 of the word 15 positions behind the one being produced
  assign s0 = {win_q[1][6:0], win_q[1][31:7]} ^ {win_q[1][17:0], win_q[1][31:18]}
            ^ (win_q[1] >> 3);

  sha256_sigma1 u_sigma1 (
    .x (win_q[14]),
    .y (s1)
  );

  assign new_word = s1 + win_q[9] + s0 + win_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    done_d  = 1'b0;

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < 15; i++) win_d[i] = win_q[i+1];
          win_d[15] = in_word;
          if (cnt_q == 6'd15) begin
            state_d = GEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      GEN: begin
        if (out_ready) begin
          // Expansion keeps running past the last emitted word; those
          // extra window entries are never presented.
          for (int unsigned i = 0; i < 15; i++) win_d[i] = win_q[i+1];
          win_d[15] = new_word;
          if (cnt_q == LAST_IDX) begin
            state_d = LOAD;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase

`ifdef SHA_SCHED_ABORT_EN
    // Abort overrides any coincident handshake; window left as-is.
    if (abort) begin
      state_d = LOAD;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == GEN);
  assign out_word  = (state_q == GEN) ? win_q[0] : '0;
  assign out_idx   = (state_q == GEN) ? cnt_q : '0;
  assign done      = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

  localparam int ROUNDS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_idx;
  logic        done;
`ifdef SHA_SCHED_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_word_q [$];
  logic [5:0]  exp_idx_q  [$];
  logic [31:0] got [64];
  logic [31:0] blk_abc  [16];
  logic [31:0] blk_zero [16];
  logic [31:0] blk_rnd  [16];

  always #5 clk = ~clk;

  sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_idx   (out_idx),
    .done      (done)
`ifdef SHA_SCHED_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule, pushed into the scoreboard when a block is driven.
  task automatic push_model(input logic [31:0] m [16]);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++)
      w[t] = sig1(w[t-2]) + w[t-7] + sig0(w[t-15]) + w[t-16];
    for (int t = 0; t < ROUNDS; t++) begin
      exp_word_q.push_back(w[t]);
      exp_idx_q.push_back(6'(t));
    end
  endtask

  task automatic feed(input logic [31:0] m [16], input int n, input bit gaps);
    int i   = 0;
    int cyc = 0;
    while (i < n && cyc < 200) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_word  = m[i];
      check1("in_ready_load", in_ready, 1'b1);
      check1("out_valid_load", out_valid, 1'b0);
      if (in_valid && in_ready) i++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    in_word  = $urandom;
    check("feed_count", 32'(i), 32'(n));
    if (n == 16) begin
      check1("first_out_valid", out_valid, 1'b1);
      check1("in_ready_drop", in_ready, 1'b0);
    end
  endtask

  task automatic drain(input bit toggle, input int stop_idx, output int hs, output int dones);
    int          cyc = 0;
    logic        stalled = 1'b0;
    logic [31:0] sw = '0;
    logic [5:0]  si = '0;
    logic [31:0] ew;
    logic [5:0]  ei;
    bit          last;
    hs    = 0;
    dones = 0;
    while (hs < ROUNDS && cyc < 1000) begin
      out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (stop_idx >= 0 && out_valid && int'(out_idx) == stop_idx) break;
      check1("out_valid_gen", out_valid, 1'b1);
      check1("in_ready_gen", in_ready, 1'b0);
      if (stalled) begin
        check("stall_word", out_word, sw);
        check("stall_idx", 32'(out_idx), 32'(si));
      end
      stalled = !out_ready;
      sw      = out_word;
      si      = out_idx;
      last    = 1'b0;
      if (out_ready && out_valid) begin
        check1("sb_nonempty", exp_word_q.size() != 0, 1'b1);
        if (exp_word_q.size() != 0) begin
          ew = exp_word_q.pop_front();
          ei = exp_idx_q.pop_front();
          check("out_word", out_word, ew);
          check("out_idx", 32'(out_idx), 32'(ei));
          got[ei] = out_word;
          last = (ei == 6'(ROUNDS - 1));
        end
        hs++;
      end
      step();
      cyc++;
      check1("done", done, last);
      if (done) dones++;
      if (last) begin
        in_valid = 1'b0;
        check1("in_ready_at_done", in_ready, 1'b1);
        check1("out_valid_at_done", out_valid, 1'b0);
        step();
        check1("done_pulse_end", done, 1'b0);
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_in_ready"}, in_ready, 1'b1);
    check1({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_word"}, out_word, 32'h0);
    check({tag, "_out_idx"}, 32'(out_idx), 32'h0);
    check1({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    int hs;
    int dones;

    for (int i = 0; i < 16; i++) begin
      blk_abc[i]  = '0;
      blk_zero[i] = '0;
      blk_rnd[i]  = $urandom;
    end
    blk_abc[0]  = 32'h61626380;
    blk_abc[15] = 32'h00000018;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
`ifdef SHA_SCHED_ABORT_EN
    abort     = 1'b0;
`endif
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // 1: "abc" block, out_ready held high
    push_model(blk_abc);
    feed(blk_abc, 16, 1'b0);
    drain(1'b0, -1, hs, dones);
    check("t1_handshakes", 32'(hs), 32'(ROUNDS));
    check("t1_dones", 32'(dones), 32'd1);
    check("abc_W0", got[0], 32'h61626380);
    check("abc_W15", got[15], 32'h00000018);
    check("abc_W16", got[16], 32'h61626380);
    check("abc_W17", got[17], 32'h000F0000);
    check("abc_W18", got[18], 32'h7DA86405);

    // 2: same block, out_ready toggling
    push_model(blk_abc);
    feed(blk_abc, 16, 1'b0);
    drain(1'b1, -1, hs, dones);
    check("t2_handshakes", 32'(hs), 32'(ROUNDS));
    check("t2_dones", 32'(dones), 32'd1);

    // 3: in_valid gaps during LOAD, in_valid held high during GEN
    push_model(blk_rnd);
    feed(blk_rnd, 16, 1'b1);
    in_valid = 1'b1;
    in_word  = 32'hDEADBEEF;
    drain(1'b0, -1, hs, dones);
    check("t3_handshakes", 32'(hs), 32'(ROUNDS));
    check("t3_queue_empty", 32'(exp_word_q.size()), 32'd0);

    // 4: back-to-back "abc" then all-zero
    push_model(blk_abc);
    feed(blk_abc, 16, 1'b0);
    drain(1'b0, -1, hs, dones);
    check("t4a_dones", 32'(dones), 32'd1);
    push_model(blk_zero);
    feed(blk_zero, 16, 1'b0);
    drain(1'b0, -1, hs, dones);
    check("t4b_dones", 32'(dones), 32'd1);
    check("t4b_W63", got[63], 32'h0);

    // 5: reset after 7 loaded words, then at out_idx=30
    feed(blk_abc, 7, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_load");
    rst = 1'b0;
    step();
    push_model(blk_rnd);
    feed(blk_rnd, 16, 1'b0);
    drain(1'b0, 30, hs, dones);
    check("t5_idx_before_rst", 32'(out_idx), 32'd30);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_gen");
    exp_word_q.delete();
    exp_idx_q.delete();
    rst = 1'b0;
    step();
    push_model(blk_abc);
    feed(blk_abc, 16, 1'b0);
    drain(1'b0, -1, hs, dones);
    check("t5_handshakes", 32'(hs), 32'(ROUNDS));
    check("t5_dones", 32'(dones), 32'd1);

`ifdef SHA_SCHED_ABORT_EN
    // 6: abort at out_idx=20 with out_ready high
    push_model(blk_rnd);
    feed(blk_rnd, 16, 1'b0);
    drain(1'b0, 20, hs, dones);
    out_ready = 1'b1;
    abort     = 1'b1;
    step();
    abort = 1'b0;
    check1("abort_done", done, 1'b0);
    check1("abort_in_ready", in_ready, 1'b1);
    check1("abort_out_valid", out_valid, 1'b0);
    exp_word_q.delete();
    exp_idx_q.delete();
    push_model(blk_abc);
    feed(blk_abc, 16, 1'b0);
    drain(1'b0, -1, hs, dones);
    check("t6_handshakes", 32'(hs), 32'(ROUNDS));
    check("t6_W18", got[18], 32'h7DA86405);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
